// File: rtl/core_rvfi_csr_tracer.sv
// ---------------------------------------------------------------------------
// core_rvfi_csr_tracer
//
// Records the CSR state at every instruction retire. Each record holds the
// retire sequence number, a per-CSR change mask (relative to the previous
// retire) and the full CSR snapshot. Records go into a small FIFO that a
// trace consumer drains with a valid/ready handshake. If the FIFO is full,
// new records are dropped. A sticky flag and a saturating counter report
// the drops.
//
// Parameters
//   XLEN  - width of one CSR value
//   NCSR  - number of tracked CSRs (index 0..NCSR-1)
//   DEPTH - record FIFO depth (power of two, >= 2)
//   MODE  - 0: record every retire, 1: record only retires that change a CSR
//
// Ports
//   g_clk, g_resetn   - clock (rising edge), asynchronous active-low reset
//   rvfi_valid        - one instruction retires this cycle
//   csr_vals          - flat CSR snapshot, CSR i at [i*XLEN +: XLEN]
//   trace_valid/ready - head-record handshake towards the consumer
//   trace_order       - retire sequence number of the head record
//   trace_mask        - bit i set when CSR i changed versus the previous retire
//   trace_vals        - CSR snapshot of the head record
//   overflow          - sticky: at least one record was dropped
//   drop_count        - number of dropped records, saturating at 0xFFFF
//   overflow_clr      - clears overflow and drop_count
// ---------------------------------------------------------------------------
module core_rvfi_csr_tracer #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NCSR  = 19,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 rvfi_valid,
  input  logic [NCSR*XLEN-1:0] csr_vals,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [63:0]          trace_order,
  output logic [NCSR-1:0]      trace_mask,
  output logic [NCSR*XLEN-1:0] trace_vals,
  output logic                 overflow,
  output logic [15:0]          drop_count,
  input  logic                 overflow_clr
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam bit          FILTER = (MODE == 1);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [63:0]          order_q, order_d;
  logic [NCSR*XLEN-1:0] prev_q, prev_d;
  logic                 first_q, first_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_count_q, drop_count_d;

  logic [63:0]          order_mem [DEPTH];
  logic [NCSR-1:0]      mask_mem  [DEPTH];
  logic [NCSR*XLEN-1:0] vals_mem  [DEPTH];

  logic [NCSR-1:0] mask;
  logic            qualify;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Per-CSR change detection. The first retire after reset has no
  // predecessor, so every CSR is reported as changed.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NCSR; i++) begin
      mask[i] = first_q | (|(csr_vals[i*XLEN +: XLEN] ^ prev_q[i*XLEN +: XLEN]));
    end
  end

  always_comb begin
    qualify = rvfi_valid & (~FILTER | (|mask));
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = ~empty & trace_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the incoming record.
    push    = qualify & (~full | pop);
    drop    = qualify & full & ~pop;
  end

  // NOTE: every signal driven in this block gets a default first. That way
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    order_d      = order_q;
    prev_d       = prev_q;
    first_d      = first_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // The counter and the reference snapshot advance on every retire. This
    // holds whether the record is stored, filtered out or dropped.
    if (rvfi_valid) begin
      order_d = order_q + 64'd1;
      prev_d  = csr_vals;
      first_d = 1'b0;
    end

    // When a clear and a drop happen in the same cycle, the clear wins for
    // the old history and the new drop is still reported.
    if (overflow_clr) begin
      overflow_d   = drop;
      drop_count_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its pre-edge value, whatever order the blocks run in.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      order_q      <= '0;
      prev_q       <= '0;
      first_q      <= 1'b1;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      order_q      <= order_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the record storage has no reset. Only entries between the read and
  // write pointers are ever observed. Resetting the pointers is enough, and
  // it keeps the array mappable to plain RAM.
  always_ff @(posedge g_clk) begin
    if (push) begin
      order_mem[wr_ptr_q[AW-1:0]] <= order_q;
      mask_mem[wr_ptr_q[AW-1:0]]  <= mask;
      vals_mem[wr_ptr_q[AW-1:0]]  <= csr_vals;
    end
  end

  // The head is taken straight from registered state. trace_valid therefore
  // rises only after the push edge and never combinationally from rvfi_valid.
  assign trace_valid = ~empty;
  assign trace_order = order_mem[rd_ptr_q[AW-1:0]];
  assign trace_mask  = mask_mem[rd_ptr_q[AW-1:0]];
  assign trace_vals  = vals_mem[rd_ptr_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_core_rvfi_csr_tracer.sv
// ---------------------------------------------------------------------------
// Testbench for core_rvfi_csr_tracer.
//
// Two instances share one stimulus: dut0 records every retire (MODE=0) and
// dut1 records only retires that change a CSR (MODE=1). A behavioural model
// per instance keeps a queue of expected records, which is pushed as retires
// are driven. The head of each DUT is compared with the front of its queue
// on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_core_rvfi_csr_tracer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NCSR  = 19;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = NCSR * XLEN;

  typedef struct packed {
    logic [63:0]     order;
    logic [NCSR-1:0] mask;
    logic [W-1:0]    vals;
  } rec_t;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b1;
  logic         rvfi_valid = 1'b0;
  logic [W-1:0] csr_vals = '0;
  logic         trace_ready = 1'b0;
  logic         overflow_clr = 1'b0;

  wire [1:0]           tv;
  wire [1:0][63:0]     to;
  wire [1:0][NCSR-1:0] tm;
  wire [1:0][W-1:0]    tvals;
  wire [1:0]           ov;
  wire [1:0][15:0]     dc;

  always #5 g_clk = ~g_clk;

  core_rvfi_csr_tracer #(.XLEN(XLEN), .NCSR(NCSR), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .rvfi_valid(rvfi_valid), .csr_vals(csr_vals),
    .trace_valid(tv[0]), .trace_ready(trace_ready), .trace_order(to[0]),
    .trace_mask(tm[0]), .trace_vals(tvals[0]), .overflow(ov[0]),
    .drop_count(dc[0]), .overflow_clr(overflow_clr)
  );

  core_rvfi_csr_tracer #(.XLEN(XLEN), .NCSR(NCSR), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .rvfi_valid(rvfi_valid), .csr_vals(csr_vals),
    .trace_valid(tv[1]), .trace_ready(trace_ready), .trace_order(to[1]),
    .trace_mask(tm[1]), .trace_vals(tvals[1]), .overflow(ov[1]),
    .drop_count(dc[1]), .overflow_clr(overflow_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance.
  logic [63:0] m_cnt   [2];
  logic [W-1:0] m_prev [2];
  bit          m_first [2];
  bit          m_ov    [2];
  logic [15:0] m_dc    [2];
  rec_t        q0[$];
  rec_t        q1[$];

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic rec_t qfront(input int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m]   = '0;
      m_prev[m]  = '0;
      m_first[m] = 1'b1;
      m_ov[m]    = 1'b0;
      m_dc[m]    = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock cycle. The task drives the inputs at posedge+1. It checks both
  // DUTs on the falling edge, then advances the model for the coming
  // rising edge.
  task automatic cycle(input bit v, input logic [W-1:0] vals, input bit rdy, input bit clr);
    rec_t            h;
    rec_t            r;
    logic [NCSR-1:0] mk;
    logic [W-1:0]    pv;
    bit              exp_v, qual, full, pop, drop;
    int              k;
    rvfi_valid   = v;
    csr_vals     = vals;
    trace_ready  = rdy;
    overflow_clr = clr;
    @(negedge g_clk);
    for (int m = 0; m < 2; m++) begin
      exp_v = (qsize(m) != 0);
      n_checks++;
      if (tv[m] !== exp_v) begin
        n_fail++;
        $display("FAIL trace_valid[%0d] t=%0t got %b exp %b", m, $time, tv[m], exp_v);
      end
      if (exp_v && tv[m] === 1'b1) begin
        h = qfront(m);
        n_checks++;
        if (to[m] !== h.order) begin
          n_fail++;
          $display("FAIL trace_order[%0d] t=%0t got %0d exp %0d", m, $time, to[m], h.order);
        end
        n_checks++;
        if (tm[m] !== h.mask) begin
          n_fail++;
          $display("FAIL trace_mask[%0d] t=%0t got %h exp %h", m, $time, tm[m], h.mask);
        end
        n_checks++;
        if (tvals[m] !== h.vals) begin
          n_fail++;
          k = 0;
          for (int i = NCSR - 1; i >= 0; i--)
            if (tvals[m][i*XLEN +: XLEN] !== h.vals[i*XLEN +: XLEN]) k = i;
          $display("FAIL trace_vals[%0d] order %0d csr %0d got %h exp %h", m, h.order, k,
                   tvals[m][k*XLEN +: XLEN], h.vals[k*XLEN +: XLEN]);
        end
      end
      n_checks++;
      if (ov[m] !== m_ov[m]) begin
        n_fail++;
        $display("FAIL overflow[%0d] t=%0t got %b exp %b", m, $time, ov[m], m_ov[m]);
      end
      n_checks++;
      if (dc[m] !== m_dc[m]) begin
        n_fail++;
        $display("FAIL drop_count[%0d] t=%0t got %0d exp %0d", m, $time, dc[m], m_dc[m]);
      end

      // Model the effect of the coming rising edge.
      pv = m_prev[m];
      for (int i = 0; i < NCSR; i++)
        mk[i] = m_first[m] | (vals[i*XLEN +: XLEN] != pv[i*XLEN +: XLEN]);
      qual = v && ((m == 0) || (mk != '0));
      full = (qsize(m) == DEPTH);
      pop  = (qsize(m) != 0) && rdy;
      drop = qual && full && !pop;
      if (pop) begin
        if (m == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      if (qual && !drop) begin
        r.order = m_cnt[m];
        r.mask  = mk;
        r.vals  = vals;
        if (m == 0) q0.push_back(r);
        else        q1.push_back(r);
      end
      if (clr) begin
        m_ov[m] = drop;
        m_dc[m] = drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        m_ov[m] = 1'b1;
        if (m_dc[m] != 16'hFFFF) m_dc[m] = m_dc[m] + 16'd1;
      end
      if (v) begin
        m_cnt[m]   = m_cnt[m] + 64'd1;
        m_prev[m]  = vals;
        m_first[m] = 1'b0;
      end
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((qsize(0) != 0 || qsize(1) != 0) && guard < 50) begin
      cycle(1'b0, csr_vals, 1'b1, 1'b0);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL drain bound expired q0=%0d q1=%0d", q0.size(), q1.size());
    end
    cycle(1'b0, csr_vals, 1'b1, 1'b0);  // ready with an empty FIFO must be ignored
  endtask

  task automatic do_reset();
    g_resetn     = 1'b0;
    rvfi_valid   = 1'b0;
    trace_ready  = 1'b0;
    overflow_clr = 1'b0;
    csr_vals     = '0;
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    g_resetn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (tv[m] !== 1'b0 || ov[m] !== 1'b0 || dc[m] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got tv=%b ov=%b dc=%0d exp 0 0 0", m, tv[m], ov[m], dc[m]);
      end
    end
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_first_retire();
    logic [W-1:0] va, vb;
    va = '0;
    va[3*XLEN +: XLEN] = 64'h5;
    cycle(1'b1, va, 1'b0, 1'b0);
    n_checks++;
    if (tv[0] !== 1'b1 || to[0] !== 64'd0 || tm[0] !== {NCSR{1'b1}}) begin
      n_fail++;
      $display("FAIL first_retire got tv=%b order=%0d mask=%h exp 1 0 all-ones", tv[0], to[0], tm[0]);
    end
    vb = va;
    vb[3*XLEN +: XLEN] = 64'h6;
    cycle(1'b1, vb, 1'b0, 1'b0);
    cycle(1'b0, vb, 1'b1, 1'b0);
    n_checks++;
    if (to[0] !== 64'd1 || tm[0] !== (NCSR'(1) << 3)) begin
      n_fail++;
      $display("FAIL second_retire got order=%0d mask=%h exp 1 %h", to[0], tm[0], NCSR'(1) << 3);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [W-1:0] v;
    do_reset();
    v = '0;
    for (int k = 0; k < 6; k++) begin
      v[0 +: XLEN] = 64'(k + 1);
      cycle(1'b1, v, 1'b0, 1'b0);
    end
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (ov[m] !== 1'b1 || dc[m] !== 16'd2 || tv[m] !== 1'b1 || to[m] !== 64'd0) begin
        n_fail++;
        $display("FAIL overflow_fill[%0d] got ov=%b dc=%0d tv=%b order=%0d exp 1 2 1 0",
                 m, ov[m], dc[m], tv[m], to[m]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] v;
    v = csr_vals;
    v[0 +: XLEN] = 64'd7;
    cycle(1'b1, v, 1'b1, 1'b0);
    n_checks++;
    if (dc[0] !== 16'd2 || to[0] !== 64'd1 || tv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop got dc=%0d order=%0d tv=%b exp 2 1 1", dc[0], to[0], tv[0]);
    end
    drain();
  endtask

  task automatic test_mode_filter();
    logic [W-1:0] va, vb;
    do_reset();
    va = '0;
    va[5*XLEN +: XLEN] = 64'hAA;
    repeat (3) cycle(1'b1, va, 1'b0, 1'b0);
    vb = va;
    vb[7*XLEN +: XLEN] = 64'h1;
    cycle(1'b1, vb, 1'b0, 1'b0);
    n_checks++;
    if (to[1] !== 64'd0 || dc[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL filter_head got order=%0d dc0=%0d exp 0 0", to[1], dc[0]);
    end
    cycle(1'b0, vb, 1'b1, 1'b0);
    n_checks++;
    if (tv[1] !== 1'b1 || to[1] !== 64'd3 || tm[1] !== (NCSR'(1) << 7)) begin
      n_fail++;
      $display("FAIL filter_next got tv=%b order=%0d mask=%h exp 1 3 %h",
               tv[1], to[1], tm[1], NCSR'(1) << 7);
    end
    drain();
  endtask

  task automatic test_overflow_clr();
    logic [W-1:0] v;
    do_reset();
    v = '0;
    for (int k = 0; k < 7; k++) begin
      v[0 +: XLEN] = 64'(k + 1);
      cycle(1'b1, v, 1'b0, (k == 6));
    end
    n_checks++;
    if (ov[0] !== 1'b1 || dc[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_with_drop got ov=%b dc=%0d exp 1 1", ov[0], dc[0]);
    end
    cycle(1'b0, v, 1'b0, 1'b1);
    n_checks++;
    if (ov[0] !== 1'b0 || dc[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_alone got ov=%b dc=%0d exp 0 0", ov[0], dc[0]);
    end
  endtask

  task automatic test_drop_saturate();
    logic [W-1:0] v;
    v = csr_vals;
    for (int k = 0; k < 65540; k++) begin
      v[0 +: XLEN] = 64'(k) + 64'h1000;
      cycle(1'b1, v, 1'b0, 1'b0);
    end
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (dc[m] !== 16'hFFFF || ov[m] !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_saturate[%0d] got dc=%h ov=%b exp ffff 1", m, dc[m], ov[m]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] v;
    #2;
    g_resetn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (tv[m] !== 1'b0 || ov[m] !== 1'b0 || dc[m] !== 16'd0) begin
        n_fail++;
        $display("FAIL mid_reset[%0d] got tv=%b ov=%b dc=%0d exp 0 0 0", m, tv[m], ov[m], dc[m]);
      end
    end
    model_reset();
    rvfi_valid = 1'b0;
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    v = '0;
    v[2*XLEN +: XLEN] = 64'h77;
    cycle(1'b1, v, 1'b0, 1'b0);
    n_checks++;
    if (to[1] !== 64'd0 || tm[1] !== {NCSR{1'b1}} || tv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_first got tv=%b order=%0d mask=%h exp 1 0 all-ones", tv[1], to[1], tm[1]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    v = csr_vals;
    for (int k = 0; k < 400; k++) begin
      v[$urandom_range(0, NCSR - 1)*XLEN +: XLEN] = 64'($urandom_range(0, 1));
      cycle($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    drain();
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    model_reset();
    test_reset();
    test_first_retire();
    test_overflow();
    test_full_push_pop();
    test_mode_filter();
    test_overflow_clr();
    test_drop_saturate();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_rvfi_csr_tracer.md
CORE_RVFI_CSR_TRACER -- requirements
Module: core_rvfi_csr_tracer

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of each CSR value.
REQ-002 SHALL have parameter NCSR, default 19: number of tracked CSRs, index 0..NCSR-1.
REQ-003 SHALL have parameter DEPTH, default 4: record FIFO depth, power of two, >= 2.
REQ-004 SHALL have parameter MODE, default 0: 0 = record every retire; 1 = record only retires with non-zero change mask.
REQ-005 SHALL have port g_clk, input, 1: sole clock, all state rising-edge.
REQ-006 SHALL have port g_resetn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port rvfi_valid, input, 1: one instruction retires this cycle.
REQ-008 SHALL have port csr_vals, input, NCSR*XLEN: flat CSR snapshot, CSR i at bits [i*XLEN +: XLEN], sampled when rvfi_valid=1.
REQ-009 SHALL have port trace_valid, output, 1: head record available.
REQ-010 SHALL have port trace_ready, input, 1: consumer accepts head record.
REQ-011 SHALL have port trace_order, output, 64: retire sequence number of head record.
REQ-012 SHALL have port trace_mask, output, NCSR: bit i set = CSR i changed versus the previous retire.
REQ-013 SHALL have port trace_vals, output, NCSR*XLEN: snapshot of head record.
REQ-014 SHALL have port overflow, output, 1: sticky, at least one record dropped.
REQ-015 SHALL have port drop_count, output, 16: dropped records, saturating at 0xFFFF.
REQ-016 SHALL have port overflow_clr, input, 1: clears overflow and drop_count.

Function
REQ-017 SHALL hold a retire counter, incremented by 1 on every rvfi_valid cycle (recorded, filtered or dropped), wrapping 2^64-1 -> 0.
REQ-018 SHALL compute mask = csr_vals XOR prev snapshot, reduced per CSR; first retire after reset SHALL yield mask all-ones.
REQ-019 SHALL update prev snapshot from csr_vals on every rvfi_valid cycle regardless of filter or drop.
REQ-020 SHALL form a record {order = counter value before increment, mask, csr_vals} on each rvfi_valid cycle; MODE=1 SHALL discard records with mask==0 without counting them as drops.
REQ-021 SHALL push a qualifying record into the FIFO; trace_valid SHALL rise the cycle after the push edge (one-cycle latency), never combinationally from rvfi_valid.
REQ-022 SHALL pop the head on a cycle with trace_valid=1 and trace_ready=1; trace_order/mask/vals SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-023 SHALL, when FIFO is full and no pop occurs that cycle, drop the incoming qualifying record, set overflow, and increment drop_count (saturating).
REQ-024 SHALL, when full with simultaneous push and pop, accept the push (no drop) and remain full.
REQ-025 SHALL, when empty, ignore trace_ready; trace_valid stays 0 and no pointer moves.
REQ-026 SHALL, on overflow_clr with a simultaneous drop, leave overflow=1 and drop_count=1.
REQ-027 SHALL use read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and remaining bits equal; empty = pointers equal.
REQ-028 SHALL deliver records in strictly increasing trace_order (mod 2^64), gaps only from MODE=1 filtering or drops.

Reset
REQ-029 SHALL, on g_resetn low, asynchronously clear FIFO pointers, retire counter, prev snapshot, first-retire flag (set), overflow and drop_count.
REQ-030 SHALL present after reset: trace_valid=0, overflow=0, drop_count=0; trace_order/mask/vals content undefined while trace_valid=0.
REQ-031 SHALL discard all queued records on reset asserted mid-operation; first post-reset record SHALL have order 0 and mask all-ones.

Verification
REQ-032 SHALL cover: reset, one retire with CSR 3 = 0x5 -> next cycle trace_valid=1, trace_order=0, trace_mask all-ones.
REQ-033 SHALL cover: second retire changing only CSR 3 to 0x6 (MODE=0) -> record order 1, trace_mask = 1<<3.
REQ-034 SHALL cover: DEPTH=4, trace_ready=0, 6 retires -> 4 records order 0..3 held, overflow=1, drop_count=2.
REQ-035 SHALL cover: full FIFO, retire with trace_ready=1 same cycle -> no drop, drop_count unchanged, next head order advances by 1.
REQ-036 SHALL cover: MODE=1, 3 retires with identical csr_vals after first -> only order 0 recorded, next change recorded with order 3.
REQ-037 SHALL cover: overflow_clr coincident with a drop -> overflow=1, drop_count=1; 0xFFFF drops -> drop_count holds 0xFFFF.
